// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: CHUNK bits per beat, valid/ready in and out, registered flags.
// Optional popcount output CNT is enabled by defining LOGIC_UNIT_SEQ_POPCNT_EN.
module logic_unit_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic             Zflag,
  output logic             Oflag,
  output logic             Pflag
`ifdef LOGIC_UNIT_SEQ_POPCNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] CNT
`endif
);

  localparam int unsigned NBEAT = WIDTH / CHUNK;
  localparam int unsigned CNTW  = (NBEAT > 1) ? $clog2(NBEAT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_err
      $error("logic_unit_seq: WIDTH must be >=1 and a multiple of CHUNK");
    end
  endgenerate

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [2:0]       r_op;
  logic [CNTW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_z;
  logic             r_zf;
  logic             r_of;
  logic             r_pf;
  logic [CHUNK-1:0] w_xs;
  logic [CHUNK-1:0] w_ys;
  logic [CHUNK-1:0] w_slice;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;
  logic             w_accept;
  logic             w_zero_next;

  // One chunk of the selected bitwise function
  function automatic logic [CHUNK-1:0] f_op(input logic [2:0] op,
                                            input logic [CHUNK-1:0] a,
                                            input logic [CHUNK-1:0] b);
    f_op = a;
    case (op)
      3'd0: f_op = a & b;
      3'd1: f_op = a | b;
      3'd2: f_op = a ^ b;
      3'd3: f_op = ~(a & b);
      3'd4: f_op = ~(a | b);
      3'd5: f_op = ~(a ^ b);
      3'd6: f_op = a & ~b;
      3'd7: f_op = a;
      default: f_op = a;
    endcase
  endfunction

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == CNTW'(NBEAT - 1));
  assign w_slice   = f_op(r_op, w_xs, w_ys);

  // Select the current beat's operand slices and merge the result slice
  always_comb begin
    w_xs       = '0;
    w_ys       = '0;
    w_acc_next = r_acc;
    for (int unsigned b = 0; b < NBEAT; b++) begin
      if (r_cnt == CNTW'(b)) begin
        w_xs = r_x[b*CHUNK +: CHUNK];
        w_ys = r_y[b*CHUNK +: CHUNK];
        w_acc_next[b*CHUNK +: CHUNK] = w_slice;
      end
    end
  end

`ifdef LOGIC_UNIT_SEQ_POPCNT_EN
  localparam int unsigned PCW = $clog2(WIDTH + 1);
  logic [PCW-1:0] r_pop;
  logic [PCW-1:0] w_spop;
  logic [PCW-1:0] w_pop_next;

  always_comb begin
    w_spop = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      w_spop = w_spop + PCW'(w_slice[i]);
    end
  end

  assign w_pop_next  = r_pop + w_spop;
  assign w_zero_next = (w_pop_next == '0);
  assign CNT         = r_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pop <= '0;
    end else if (w_accept) begin
      r_pop <= '0;
    end else if (r_state == S_BUSY) begin
      r_pop <= w_pop_next;
    end
  end
`else
  assign w_zero_next = (w_acc_next == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = in_valid ? S_BUSY : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, beat accumulation, and result/flag capture on the final beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_op  <= '0;
      r_cnt <= '0;
      r_acc <= '0;
      r_z   <= '0;
      r_zf  <= 1'b1;
      r_of  <= 1'b0;
      r_pf  <= 1'b0;
    end else if (w_accept) begin
      r_x   <= X;
      r_y   <= Y;
      r_op  <= OP;
      r_cnt <= '0;
      r_acc <= '0;
    end else if (r_state == S_BUSY) begin
      r_acc <= w_acc_next;
      if (w_last) begin
        r_cnt <= '0;
        r_z   <= w_acc_next;
        r_zf  <= w_zero_next;
        r_of  <= &w_acc_next;
        r_pf  <= ^w_acc_next;
      end else begin
        r_cnt <= r_cnt + CNTW'(1);
      end
    end
  end

  assign Z     = r_z;
  assign Zflag = r_zf;
  assign Oflag = r_of;
  assign Pflag = r_pf;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Randomised and directed bench for logic_unit_seq: an 8/8 instance and a 16/4 instance
// checked against a whole-word behavioural model.
module tb_logic_unit_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv   [2];
  logic        ordy [2];
  logic [2:0]  op   [2];
  logic [15:0] x    [2];
  logic [15:0] y    [2];

  logic        ir8, ov8, zf8, of8, pf8;
  logic [7:0]  z8;
  logic        ir16, ov16, zf16, of16, pf16;
  logic [15:0] z16;
`ifdef LOGIC_UNIT_SEQ_POPCNT_EN
  logic [3:0]  cnt8;
  logic [4:0]  cnt16;
`endif

  logic        ir [2];
  logic        ov [2];
  logic        zf [2];
  logic        of [2];
  logic        pf [2];
  logic [15:0] zz [2];

  assign ir[0] = ir8;  assign ir[1] = ir16;
  assign ov[0] = ov8;  assign ov[1] = ov16;
  assign zf[0] = zf8;  assign zf[1] = zf16;
  assign of[0] = of8;  assign of[1] = of16;
  assign pf[0] = pf8;  assign pf[1] = pf16;
  assign zz[0] = {8'h00, z8};
  assign zz[1] = z16;

  logic_unit_seq #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir8), .OP(op[0]), .X(x[0][7:0]), .Y(y[0][7:0]),
    .out_valid(ov8), .out_ready(ordy[0]),
    .Z(z8), .Zflag(zf8), .Oflag(of8), .Pflag(pf8)
`ifdef LOGIC_UNIT_SEQ_POPCNT_EN
    , .CNT(cnt8)
`endif
  );

  logic_unit_seq #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir16), .OP(op[1]), .X(x[1]), .Y(y[1]),
    .out_valid(ov16), .out_ready(ordy[1]),
    .Z(z16), .Zflag(zf16), .Oflag(of16), .Pflag(pf16)
`ifdef LOGIC_UNIT_SEQ_POPCNT_EN
    , .CNT(cnt16)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mask_of(input int u);
    return (u == 1) ? 16'hFFFF : 16'h00FF;
  endfunction

  // Whole-word reference result, truncated to the instance width
  function automatic logic [15:0] model(input logic [2:0] o, input logic [15:0] a,
                                        input logic [15:0] b, input int u);
    logic [15:0] r;
    case (o)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a & b);
      3'd4: r = ~(a | b);
      3'd5: r = ~(a ^ b);
      3'd6: r = a & ~b;
      default: r = a;
    endcase
    return r & mask_of(u);
  endfunction

  // Present an op from IDLE; returns at the falling edge just after the accept edge
  task automatic start(input int u, input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    chk("in_ready_idle", 32'(ir[u]), 32'd1);
    op[u] = o; x[u] = a; y[u] = b; iv[u] = 1'b1;
    @(negedge clk);
    iv[u] = 1'b0;
    op[u] = 3'($urandom); x[u] = 16'($urandom); y[u] = 16'($urandom);
  endtask

  task automatic wait_done(input int u);
    int n;
    n = 0;
    while (!ov[u] && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("latency_beats", 32'(n), (u == 1) ? 32'd4 : 32'd1);
  endtask

  task automatic check_res(input int u, input logic [15:0] e);
    chk("out_valid", 32'(ov[u]), 32'd1);
    chk("Z", 32'(zz[u]), 32'(e));
    chk("Zflag", 32'(zf[u]), 32'(e == 16'h0));
    chk("Oflag", 32'(of[u]), 32'(e == mask_of(u)));
    chk("Pflag", 32'(pf[u]), 32'(^e));
`ifdef LOGIC_UNIT_SEQ_POPCNT_EN
    chk("CNT", (u == 1) ? 32'(cnt16) : 32'(cnt8), 32'($countones(e)));
`endif
  endtask

  // Hold the result with in_valid noise, then consume it
  task automatic consume(input int u, input logic [15:0] e, input int hold);
    for (int i = 0; i < hold; i++) begin
      iv[u] = 1'b1; op[u] = 3'($urandom); x[u] = 16'($urandom); y[u] = 16'($urandom);
      @(negedge clk);
      chk("hold_in_ready", 32'(ir[u]), 32'd0);
      chk("hold_valid", 32'(ov[u]), 32'd1);
      chk("hold_Z", 32'(zz[u]), 32'(e));
    end
    iv[u] = 1'b0;
    ordy[u] = 1'b1;
    @(negedge clk);
    ordy[u] = 1'b0;
    chk("valid_dropped", 32'(ov[u]), 32'd0);
    chk("Z_kept", 32'(zz[u]), 32'(e));
  endtask

  task automatic do_op(input int u, input logic [2:0] o, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] e, input int hold);
    start(u, o, a, b);
    wait_done(u);
    check_res(u, e);
    consume(u, e, hold);
  endtask

  task automatic check_reset_vals(input int u);
    chk("rst_in_ready", 32'(ir[u]), 32'd1);
    chk("rst_out_valid", 32'(ov[u]), 32'd0);
    chk("rst_Z", 32'(zz[u]), 32'd0);
    chk("rst_Zflag", 32'(zf[u]), 32'd1);
    chk("rst_Oflag", 32'(of[u]), 32'd0);
    chk("rst_Pflag", 32'(pf[u]), 32'd0);
  endtask

  initial begin
    int seen;
    logic [2:0]  ro;
    logic [15:0] ra, rb;
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      iv[u] = 1'b0; ordy[u] = 1'b0; op[u] = '0; x[u] = '0; y[u] = '0;
    end
    repeat (3) @(negedge clk);
    check_reset_vals(0);
    check_reset_vals(1);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals(0);

    do_op(0, 3'd0, 16'h00F0, 16'h003C, 16'h0030, 0);
    do_op(1, 3'd5, 16'hA5A5, 16'h5A5A, 16'h0000, 0);
    do_op(1, 3'd3, 16'h0000, 16'h0000, 16'hFFFF, 1);
    do_op(1, 3'd1, 16'h0F00, 16'h00F1, 16'h0FF1, 2);

    // Backpressure then same-cycle consume and accept
    start(1, 3'd6, 16'hF0F0, 16'h3C3C);
    wait_done(1);
    check_res(1, 16'hC0C0);
    iv[1] = 1'b1; op[1] = 3'd2; x[1] = 16'h1234; y[1] = 16'h00FF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(ir[1]), 32'd0);
      chk("bp_valid", 32'(ov[1]), 32'd1);
      chk("bp_Z", 32'(zz[1]), 32'hC0C0);
    end
    ordy[1] = 1'b1;
    #1;
    chk("same_cycle_ready", 32'(ir[1]), 32'd1);
    @(negedge clk);
    iv[1] = 1'b0; ordy[1] = 1'b0;
    x[1] = 16'hFFFF; y[1] = 16'hFFFF; op[1] = 3'd4;
    chk("b2b_valid_drop", 32'(ov[1]), 32'd0);
    chk("b2b_Z_kept", 32'(zz[1]), 32'hC0C0);
    wait_done(1);
    check_res(1, 16'h12CB);
    consume(1, 16'h12CB, 0);

    // Reset during the second beat discards the op
    start(1, 3'd7, 16'hBEEF, 16'h0000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals(1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov[1]) seen++;
    end
    chk("no_valid_after_reset", 32'(seen), 32'd0);
    chk("Z_after_reset", 32'(zz[1]), 32'd0);

    for (int i = 0; i < 24; i++) begin
      int u;
      u  = i % 2;
      ro = 3'($urandom);
      ra = 16'($urandom);
      rb = 16'($urandom);
      do_op(u, ro, ra, rb, model(ro, ra, rb, u), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
